// File: rtl/mipi_dphy_tx_lane_pkg.sv
// Shared D-PHY lane definitions: sequencer states, sync byte and LP line levels.
package mipi_dphy_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LPX   = 3'd1,
      ST_PREP  = 3'd2,
      ST_ZERO  = 3'd3,
      ST_SYNC  = 3'd4,
      ST_DATA  = 3'd5,
      ST_TRAIL = 3'd6,
      ST_EXIT  = 3'd7
   } lane_state_e;

   localparam logic [7:0] MIPI_SYNC_BYTE = 8'hB8;
   localparam logic [1:0] LP11 = 2'b11;
   localparam logic [1:0] LP01 = 2'b01;
   localparam logic [1:0] LP00 = 2'b00;

   // The trailer holds the inverse of the final bit on the wire (bit7, LSB-first serializer).
   function automatic logic [7:0] trail_fill(input logic [7:0] last_byte);
      return {8{~last_byte[7]}};
   endfunction

endpackage

// File: rtl/mipi_dphy_tx_lane_if.sv
// Payload byte stream into the lane sequencer (valid/ready with end-of-burst marker).
interface mipi_dphy_tx_lane_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_ready;

   modport master (output tx_valid, output tx_data, output tx_last, input tx_ready);
   modport slave  (input tx_valid, input tx_data, input tx_last, output tx_ready);
endinterface

// File: rtl/mipi_tx_phase_timer.sv
// Loadable down-counter timing each LP/HS phase; done is high in the phase's final cycle.
module mipi_tx_phase_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt_r;

   // Count register: a zero load is clamped to one so every phase lasts at least a cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (load) begin
         cnt_r <= (load_val == {CNT_W{1'b0}}) ? CNT_W'(1) : load_val;
      end else if (cnt_r != {CNT_W{1'b0}}) begin
         cnt_r <= cnt_r - CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign done = (cnt_r == CNT_W'(1));

endmodule

// File: rtl/mipi_dphy_tx_lane.sv
// Single-lane D-PHY HS burst sequencer: LP entry, HS-zero, sync, payload, trailer, LP-11 exit.
module mipi_dphy_tx_lane
   import mipi_dphy_pkg::*;
#(
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned T_LPX        = 2,
   parameter int unsigned T_HS_PREPARE = 2,
   parameter int unsigned T_HS_ZERO    = 4,
   parameter int unsigned T_HS_TRAIL   = 3,
   parameter int unsigned T_HS_EXIT    = 3
) (
   input  logic                byte_clk,
   input  logic                sys_rst_n,
   mipi_dphy_tx_lane_if.slave  tx,
   output logic [1:0]          lp_data_o,
   output logic                hs_oe,
   output logic [7:0]          hs_data_o,
   output logic                busy,
   output logic                err_underflow
);

   lane_state_e      state_r, state_nx_s;
   logic             last_r;
   logic             ready_s, take_s, err_nx_s, load_s, done_s;
   logic [CNT_W-1:0] load_val_s;
   logic [1:0]       lp_nx_s;
   logic             oe_nx_s;
   logic [7:0]       hs_nx_s;

   assign ready_s     = (state_r == ST_SYNC) || ((state_r == ST_DATA) && !last_r);
   assign take_s      = ready_s && tx.tx_valid;
   assign tx.tx_ready = ready_s;

   mipi_tx_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (byte_clk),
      .rst_n    (sys_rst_n),
      .load     (load_s),
      .load_val (load_val_s),
      .done     (done_s)
   );

   // Next-state decode; the phase timer is loaded on entry to every timed state.
   always_comb begin
      state_nx_s = state_r;
      load_s     = 1'b0;
      load_val_s = {CNT_W{1'b0}};
      err_nx_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (tx.tx_valid) begin
               state_nx_s = ST_LPX;
               load_s     = 1'b1;
               load_val_s = CNT_W'(T_LPX);
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_LPX: begin
            if (done_s) begin
               state_nx_s = ST_PREP;
               load_s     = 1'b1;
               load_val_s = CNT_W'(T_HS_PREPARE);
            end else begin
               state_nx_s = ST_LPX;
            end
         end
         ST_PREP: begin
            if (done_s) begin
               state_nx_s = ST_ZERO;
               load_s     = 1'b1;
               load_val_s = CNT_W'(T_HS_ZERO);
            end else begin
               state_nx_s = ST_PREP;
            end
         end
         ST_ZERO: begin
            if (done_s) begin
               state_nx_s = ST_SYNC;
            end else begin
               state_nx_s = ST_ZERO;
            end
         end
         ST_SYNC, ST_DATA: begin
            if (take_s) begin
               state_nx_s = ST_DATA;
            end else begin
               // Either the marked last byte went out or the source starved the stream.
               state_nx_s = ST_TRAIL;
               load_s     = 1'b1;
               load_val_s = CNT_W'(T_HS_TRAIL);
               err_nx_s   = ready_s;
            end
         end
         ST_TRAIL: begin
            if (done_s) begin
               state_nx_s = ST_EXIT;
               load_s     = 1'b1;
               load_val_s = CNT_W'(T_HS_EXIT);
            end else begin
               state_nx_s = ST_TRAIL;
            end
         end
         ST_EXIT: begin
            if (done_s) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_EXIT;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Output values for the state being entered, so the registered outputs line up with it.
   always_comb begin
      lp_nx_s = LP00;
      oe_nx_s = 1'b1;
      hs_nx_s = 8'h00;
      case (state_nx_s)
         ST_IDLE, ST_EXIT: begin
            lp_nx_s = LP11;
            oe_nx_s = 1'b0;
         end
         ST_LPX: begin
            lp_nx_s = LP01;
            oe_nx_s = 1'b0;
         end
         ST_PREP: begin
            oe_nx_s = 1'b0;
         end
         ST_ZERO: begin
            hs_nx_s = 8'h00;
         end
         ST_SYNC: begin
            hs_nx_s = MIPI_SYNC_BYTE;
         end
         ST_DATA: begin
            if (take_s) begin
               hs_nx_s = tx.tx_data;
            end else begin
               hs_nx_s = hs_data_o;
            end
         end
         ST_TRAIL: begin
            if (state_r == ST_TRAIL) begin
               hs_nx_s = hs_data_o;
            end else begin
               hs_nx_s = trail_fill(hs_data_o);
            end
         end
         default: begin
            lp_nx_s = LP11;
            oe_nx_s = 1'b0;
         end
      endcase
   end

   // State, last-byte flag and registered lane outputs.
   always_ff @(posedge byte_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r       <= ST_IDLE;
         last_r        <= 1'b0;
         lp_data_o     <= LP11;
         hs_oe         <= 1'b0;
         hs_data_o     <= 8'h00;
         busy          <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         state_r       <= state_nx_s;
         last_r        <= take_s ? tx.tx_last : last_r;
         lp_data_o     <= lp_nx_s;
         hs_oe         <= oe_nx_s;
         hs_data_o     <= hs_nx_s;
         busy          <= (state_nx_s != ST_IDLE);
         err_underflow <= err_nx_s;
      end
   end

endmodule

// File: tb/tb_mipi_dphy_tx_lane.sv
// Self-checking bench: per-cycle lane trace compared with a timeline built from the burst rules.
module tb_mipi_dphy_tx_lane;

   localparam int T_LPX        = 2;
   localparam int T_HS_PREPARE = 2;
   localparam int T_HS_ZERO    = 4;
   localparam int T_HS_TRAIL   = 3;
   localparam int T_HS_EXIT    = 3;

   typedef struct packed {
      logic [1:0] lp;
      logic       oe;
      logic [7:0] hs;
      logic       busy;
      logic       rdy;
      logic       err;
   } obs_t;

   logic       byte_clk = 1'b0;
   logic       sys_rst_n;
   logic [1:0] lp_data_o;
   logic       hs_oe;
   logic [7:0] hs_data_o;
   logic       busy;
   logic       err_underflow;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] pay [0:7];
   obs_t       exp_q [$];

   mipi_dphy_tx_lane_if tif ();

   mipi_dphy_tx_lane #(
      .CNT_W(8), .T_LPX(T_LPX), .T_HS_PREPARE(T_HS_PREPARE),
      .T_HS_ZERO(T_HS_ZERO), .T_HS_TRAIL(T_HS_TRAIL), .T_HS_EXIT(T_HS_EXIT)
   ) dut (
      .byte_clk      (byte_clk),
      .sys_rst_n     (sys_rst_n),
      .tx            (tif),
      .lp_data_o     (lp_data_o),
      .hs_oe         (hs_oe),
      .hs_data_o     (hs_data_o),
      .busy          (busy),
      .err_underflow (err_underflow)
   );

   always #5 byte_clk = ~byte_clk;

   function automatic obs_t mk(input logic [1:0] lp, input logic oe, input logic [7:0] hs,
                               input logic b, input logic r, input logic e);
      obs_t v;
      v.lp = lp; v.oe = oe; v.hs = hs; v.busy = b; v.rdy = r; v.err = e;
      return v;
   endfunction

   task automatic check(input string tag, input int cyc, input obs_t want);
      obs_t got;
      got = mk(lp_data_o, hs_oe, hs_data_o, busy, tif.tx_ready, err_underflow);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s cyc=%0d got lp=%b oe=%b hs=%h busy=%b rdy=%b err=%b want lp=%b oe=%b hs=%h busy=%b rdy=%b err=%b",
                tag, cyc, got.lp, got.oe, got.hs, got.busy, got.rdy, got.err,
                want.lp, want.oe, want.hs, want.busy, want.rdy, want.err);
      end
   endtask

   // Expected lane trace for cycles 1..end of a burst of n bytes (u: source starves after byte n).
   task automatic build_exp(input int n, input bit u);
      logic [7:0] fill;
      exp_q.delete();
      for (int i = 0; i < T_LPX; i++)        exp_q.push_back(mk(2'b01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
      for (int i = 0; i < T_HS_PREPARE; i++) exp_q.push_back(mk(2'b00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
      for (int i = 0; i < T_HS_ZERO; i++)    exp_q.push_back(mk(2'b00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(mk(2'b00, 1'b1, 8'hB8, 1'b1, 1'b1, 1'b0));
      for (int i = 0; i < n; i++)
         exp_q.push_back(mk(2'b00, 1'b1, pay[i], 1'b1, ((i < n - 1) || u) ? 1'b1 : 1'b0, 1'b0));
      fill = pay[n-1];
      fill = fill[7] ? 8'h00 : 8'hFF;
      for (int i = 0; i < T_HS_TRAIL; i++)
         exp_q.push_back(mk(2'b00, 1'b1, fill, 1'b1, 1'b0, (i == 0 && u) ? 1'b1 : 1'b0));
      for (int i = 0; i < T_HS_EXIT; i++)    exp_q.push_back(mk(2'b11, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(mk(2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
   endtask

   task automatic idle(input int k);
      for (int c = 0; c < k; c++) begin
         @(posedge byte_clk); @(negedge byte_clk);
         check("idle", c, mk(2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
         tif.tx_valid = 1'b0;
      end
   endtask

   // Request at edge 0, feed pay[0..n-1]; hold keeps valid high after the burst; abort>0 resets at that cycle.
   task automatic run_burst(input int n, input bit u, input bit hold, input int abort);
      int len;
      int s;
      build_exp(n, u);
      len = exp_q.size();
      s   = T_LPX + T_HS_PREPARE + T_HS_ZERO + 1;
      tif.tx_valid = 1'b1;
      tif.tx_data  = 8'($urandom);
      tif.tx_last  = 1'b0;
      for (int cyc = 1; cyc <= len; cyc++) begin
         @(posedge byte_clk); @(negedge byte_clk);
         check("burst", cyc, exp_q[cyc-1]);
         if (abort == cyc) begin
            sys_rst_n    = 1'b0;
            tif.tx_valid = 1'b0;
            #1;
            check("rst_async", cyc, mk(2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
            @(negedge byte_clk);
            check("rst_hold", cyc, mk(2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
            sys_rst_n = 1'b1;
            return;
         end
         tif.tx_data = 8'($urandom);
         tif.tx_last = 1'($urandom);
         if (cyc < s) begin
            tif.tx_valid = 1'($urandom);
         end else if (cyc < s + n) begin
            tif.tx_valid = 1'b1;
            tif.tx_data  = pay[cyc-s];
            tif.tx_last  = ((cyc - s == n - 1) && !u) ? 1'b1 : 1'b0;
         end else begin
            tif.tx_valid = hold;
         end
      end
   endtask

   initial begin
      int n;
      bit u;
      sys_rst_n    = 1'b0;
      tif.tx_valid = 1'b0;
      tif.tx_data  = 8'h00;
      tif.tx_last  = 1'b0;
      #12;
      check("reset", 0, mk(2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
      tif.tx_valid = 1'b1;
      @(negedge byte_clk);
      check("reset_req", 0, mk(2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
      tif.tx_valid = 1'b0;
      sys_rst_n    = 1'b1;
      idle(2);

      pay[0] = 8'h5A;
      run_burst(1, 1'b0, 1'b0, 0);
      idle(1);

      pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h83;
      run_burst(3, 1'b0, 1'b0, 0);

      pay[0] = 8'h10;
      run_burst(1, 1'b1, 1'b0, 0);
      idle(1);

      pay[0] = 8'h77; pay[1] = 8'h88;
      run_burst(2, 1'b0, 1'b0, 6);
      pay[0] = 8'h5A;
      run_burst(1, 1'b0, 1'b0, 0);

      pay[0] = 8'hC3;
      run_burst(1, 1'b0, 1'b1, 0);
      pay[0] = 8'h3C; pay[1] = 8'h81;
      run_burst(2, 1'b0, 1'b0, 0);

      for (int b = 0; b < 10; b++) begin
         n = $urandom_range(1, 6);
         u = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
         run_burst(n, u, 1'b0, 0);
         idle($urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
